// File: rtl/chip8_audio_pkg.sv
// rtl/chip8_audio_pkg.sv - shared types and defaults for the PDM capture path
package chip8_audio_pkg;

    // Capture FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } pdm_state_t;

    // Microphone bit clock: clk_in cycles per bit period
    localparam int DEF_CLK_DIV     = 32;

    // log2 of PDM bits summed into one PCM sample
    localparam int DEF_WINDOW_LOG2 = 10;

    // PCM sample width and the offset that turns an unsigned count into two's complement
    localparam int         SAMPLE_W    = 8;
    localparam logic [7:0] SAMPLE_BIAS = 8'h80;

endpackage

// File: rtl/pdm_clk_gen.sv
// rtl/pdm_clk_gen.sv - microphone bit clock divider and PDM sampling tick
module pdm_clk_gen #(
    parameter int CLK_DIV = 32
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic run_in,
    output logic mic_clk_out,
    output logic tick_out
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_next;
    logic          r_mic_clk;

    // Divider wraps at CLK_DIV-1; mic clock is high for the first half of the count
    assign w_div_next  = (r_div == DW'(CLK_DIV - 1)) ? '0 : r_div + 1'b1;
    assign tick_out    = run_in && (r_div == DW'(CLK_DIV - 1));
    assign mic_clk_out = r_mic_clk;

    // Divider and registered bit clock; both parked at zero when not running
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_div     <= '0;
            r_mic_clk <= 1'b0;
        end else if (!run_in) begin
            r_div     <= '0;
            r_mic_clk <= 1'b0;
        end else begin
            r_div     <= w_div_next;
            r_mic_clk <= (w_div_next < DW'(CLK_DIV / 2));
        end
    end

endmodule

// File: rtl/pdm_decimator.sv
// rtl/pdm_decimator.sv - PDM microphone to 8-bit PCM boxcar decimator with sample handshake
module pdm_decimator
    import chip8_audio_pkg::*;
#(
    parameter int CLK_DIV        = DEF_CLK_DIV,
    parameter int WINDOW_LOG2    = DEF_WINDOW_LOG2,
    parameter int SETTLE_WINDOWS = 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                enable_in,
    input  logic                pdm_in,
    output logic                mic_clk_out,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid_out,
    input  logic                sample_ready_in,
    output logic                overrun_out,
    input  logic                overrun_clr_in
);

    localparam int SHIFT = WINDOW_LOG2 - 8;

    pdm_state_t            r_state;
    pdm_state_t            w_state_next;
    logic [15:0]           r_settle_cnt;
    logic [15:0]           w_settle_next;
    logic                  r_en_d;
    logic                  w_run;
    logic                  w_tick;
    logic                  w_win_end;
    logic                  w_load;
    logic [WINDOW_LOG2-1:0] r_bit_cnt;
    logic [WINDOW_LOG2:0]   r_ones;
    logic [WINDOW_LOG2:0]   w_total;
    logic [WINDOW_LOG2:0]   w_shifted;
    logic [SAMPLE_W-1:0]    w_sat;
    logic [SAMPLE_W-1:0]    r_sample;
    logic                   r_valid;
    logic                   r_overrun;

    // Enable low stops the bit clock in the same cycle, so a window cannot end after enable falls
    assign w_run = enable_in && (r_state != ST_IDLE);

    pdm_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .run_in      (w_run),
        .mic_clk_out (mic_clk_out),
        .tick_out    (w_tick)
    );

    assign w_win_end = w_tick && (&r_bit_cnt);
    assign w_total   = r_ones + (WINDOW_LOG2 + 1)'(pdm_in);
    assign w_shifted = w_total >> SHIFT;
    assign w_sat     = (|w_shifted[WINDOW_LOG2:8]) ? 8'hFF : w_shifted[7:0];

    // Window accumulation: count bits and ones per tick, restart at each window end
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_bit_cnt <= '0;
            r_ones    <= '0;
        end else if (!w_run) begin
            r_bit_cnt <= '0;
            r_ones    <= '0;
        end else if (w_tick) begin
            if (&r_bit_cnt) begin
                r_bit_cnt <= '0;
                r_ones    <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_ones    <= w_total;
            end
        end
    end

    // State, settle counter and enable history for rise detection
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_en_d       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_settle_cnt <= w_settle_next;
            r_en_d       <= enable_in;
        end
    end

    // Next-state logic; only window ends seen in RUN produce a sample
    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle_cnt;
        w_load        = 1'b0;
        if (!enable_in) begin
            w_state_next  = ST_IDLE;
            w_settle_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_settle_next = '0;
                    if (!r_en_d) begin
                        w_state_next = (SETTLE_WINDOWS == 0) ? ST_RUN : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_win_end) begin
                        if (r_settle_cnt == 16'(SETTLE_WINDOWS - 1)) begin
                            w_state_next = ST_RUN;
                        end else begin
                            w_settle_next = r_settle_cnt + 16'd1;
                        end
                    end
                end
                ST_RUN: begin
                    w_load = w_win_end;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Output sample register with valid/ready handshake and sticky overrun
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_sample <= w_sat ^ SAMPLE_BIAS;
                r_valid  <= 1'b1;
            end else if (r_valid && sample_ready_in) begin
                r_valid  <= 1'b0;
            end
            if (w_load && r_valid && !sample_ready_in) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr_in) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign sample_out       = r_sample;
    assign sample_valid_out = r_valid;
    assign overrun_out      = r_overrun;

endmodule

// File: tb/tb_pdm_decimator.sv
// tb/tb_pdm_decimator.sv - directed self-checking bench for pdm_decimator
module tb_pdm_decimator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en8, lvl8, alt8, alt_bit, rdy8, clr8, mic8, vld8, ovr8;
    logic       pdm8;
    logic [7:0] smp8;
    logic       en10, rdy10, clr10, mic10, vld10, ovr10;
    logic       pdm10;
    logic [7:0] smp10;
    int         ph10 = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc;

    always #5 clk = ~clk;

    pdm_decimator #(.CLK_DIV(32), .WINDOW_LOG2(8), .SETTLE_WINDOWS(1)) dut (
        .clk_in(clk), .rst_in(rst_n), .enable_in(en8), .pdm_in(pdm8),
        .mic_clk_out(mic8), .sample_out(smp8), .sample_valid_out(vld8),
        .sample_ready_in(rdy8), .overrun_out(ovr8), .overrun_clr_in(clr8)
    );

    pdm_decimator #(.CLK_DIV(4), .WINDOW_LOG2(10), .SETTLE_WINDOWS(1)) dut10 (
        .clk_in(clk), .rst_in(rst_n), .enable_in(en10), .pdm_in(pdm10),
        .mic_clk_out(mic10), .sample_out(smp10), .sample_valid_out(vld10),
        .sample_ready_in(rdy10), .overrun_out(ovr10), .overrun_clr_in(clr10)
    );

    // Alternating pattern changes on the mic clock falling edge, well before each sampling tick
    always @(negedge mic8) alt_bit = ~alt_bit;
    assign pdm8 = alt8 ? alt_bit : lvl8;

    // Three ones then a zero per four bit periods: 768 ones per 1024-bit window
    always @(negedge mic10) ph10 = (ph10 + 1) % 4;
    assign pdm10 = (ph10 != 3);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid8(input int bound, output int c);
        c = 0;
        while (vld8 !== 1'b1 && c < bound) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic wait_valid10(input int bound, output int c);
        c = 0;
        while (vld10 !== 1'b1 && c < bound) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic accept8();
        rdy8 = 1'b1;
        @(negedge clk);
        rdy8 = 1'b0;
        check("accept_clears_valid", vld8, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        en8 = 1'b0; lvl8 = 1'b0; alt8 = 1'b0; alt_bit = 1'b0; rdy8 = 1'b0; clr8 = 1'b0;
        en10 = 1'b0; rdy10 = 1'b0; clr10 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_sample", smp8, 8'h00);
        check("reset_valid", vld8, 1'b0);
        check("reset_overrun", ovr8, 1'b0);
        check("reset_mic_clk", mic8, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // WINDOW_LOG2=10: 768 ones -> r=192 -> 8'h40
        en10 = 1'b1;
        wait_valid10(8300, cyc);
        check("w10_valid", vld10, 1'b1);
        check("w10_sample", smp10, 8'h40);
        check("w10_latency", (cyc >= 8192 && cyc <= 8193), 1'b1);
        en10 = 1'b0;
        @(negedge clk);

        // All ones saturates to 255 -> 8'h7F after one settle window plus one window
        lvl8 = 1'b1;
        en8 = 1'b1;
        check("idle_mic_clk_low", mic8, 1'b0);
        wait_valid8(16500, cyc);
        check("ones_valid", vld8, 1'b1);
        check("ones_sample", smp8, 8'h7F);
        check("ones_latency", (cyc >= 16384 && cyc <= 16385), 1'b1);
        lvl8 = 1'b0;
        accept8();

        // All zeros -> -128
        wait_valid8(8300, cyc);
        check("zeros_valid", vld8, 1'b1);
        check("zeros_sample", smp8, 8'h80);
        alt8 = 1'b1;
        accept8();

        // Alternating 1,0 -> 128 ones -> 8'h00
        wait_valid8(8300, cyc);
        check("alt_valid", vld8, 1'b1);
        check("alt_sample", smp8, 8'h00);
        check("alt_no_overrun", ovr8, 1'b0);
        alt8 = 1'b0;
        lvl8 = 1'b1;

        // Unconsumed sample overwritten at the next window end
        repeat (8192) @(negedge clk);
        check("ovr_sample", smp8, 8'h7F);
        check("ovr_valid", vld8, 1'b1);
        check("ovr_flag", ovr8, 1'b1);
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        check("ovr_cleared", ovr8, 1'b0);
        check("ovr_valid_kept", vld8, 1'b1);

        // Asynchronous reset mid-window clears outputs immediately
        repeat (4000) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_sample", smp8, 8'h00);
        check("mid_rst_valid", vld8, 1'b0);
        check("mid_rst_overrun", ovr8, 1'b0);
        check("mid_rst_mic_clk", mic8, 1'b0);
        en8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        en8 = 1'b1;
        wait_valid8(16500, cyc);
        check("post_rst_valid", vld8, 1'b1);
        check("post_rst_latency", (cyc >= 16384 && cyc <= 16385), 1'b1);
        check("post_rst_sample", smp8, 8'h7F);

        // Drop enable during the final tick of the next window
        accept8();
        repeat (8190) @(negedge clk);
        en8 = 1'b0;
        @(negedge clk);
        check("drop_no_valid", vld8, 1'b0);
        check("drop_mic_clk_low", mic8, 1'b0);
        repeat (40) @(negedge clk);
        check("drop_no_late_valid", vld8, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
